mcdt_nch: RTL and testbench
===========================

MCDT_NCH -- requirements
Module: mcdt_nch

Interface
REQ-001 SHALL have parameter NCH, default 3, number of input channels (legal 2..8).
REQ-002 SHALL have parameter DW, default 32, data width per channel.
REQ-003 SHALL have parameter DEPTH, default 32, per-channel FIFO depth (power of 2, >=2).
REQ-004 SHALL use derived widths MW=$clog2(DEPTH)+1 for margin and IW=$clog2(NCH) for id.
REQ-005 SHALL have port clk_i, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_i, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port ch_data_i, input, NCH*DW: channel n data in slice [n*DW +: DW].
REQ-008 SHALL have port ch_valid_i, input, NCH: per-channel write request.
REQ-009 SHALL have port ch_ready_o, output, NCH: per-channel FIFO not full.
REQ-010 SHALL have port ch_margin_o, output, NCH*MW: per-channel free FIFO slots, slice [n*MW +: MW].
REQ-011 SHALL have port mcdt_data_o, output, DW: merged output data.
REQ-012 SHALL have port mcdt_val_o, output, 1: output word valid.
REQ-013 SHALL have port mcdt_id_o, output, IW: source channel of mcdt_data_o.
REQ-014 SHALL have port mcdt_ready_i, input, 1: downstream accepts the word (backpressure; new vs previous generation).

Function
REQ-015 SHALL write channel n FIFO at an edge where ch_valid_i[n] & ch_ready_o[n]; ch_valid_i while full SHALL be ignored, not stalled.
REQ-016 SHALL drive ch_ready_o[n] = (ch_margin_o[n] != 0), combinationally from registered count.
REQ-017 SHALL keep ch_margin_o[n] = DEPTH - occupancy of FIFO n; output register excluded.
REQ-018 SHALL leave margin unchanged on simultaneous push and pop of the same FIFO.
REQ-019 SHALL preserve per-channel order; no word lost or duplicated.
REQ-020 SHALL hold a single output register; it loads when empty or when mcdt_val_o & mcdt_ready_i at that edge.
REQ-021 SHALL keep mcdt_data_o/mcdt_id_o stable while mcdt_val_o=1 and mcdt_ready_i=0.
REQ-022 SHALL request only from non-empty FIFOs; no request -> mcdt_val_o falls after consumption.
REQ-023 SHALL give latency: word written at edge k appears with mcdt_val_o=1 after edge k+1 (no contention, output free).
REQ-024 SHALL sustain one output word per cycle aggregate while mcdt_ready_i=1 and any FIFO non-empty.
REQ-025 SHALL arbitrate round-robin by default: after grant to n, search starts at (n+1) mod NCH; pointer advances only on a load.
REQ-026 SHALL pointer wrap NCH-1 -> 0; a lone requester is granted every cycle.

Reset
REQ-027 SHALL on rst_i=1, asynchronously: all FIFOs empty, ch_margin_o=DEPTH, ch_ready_o all 1, mcdt_val_o=0, mcdt_data_o=0, mcdt_id_o=0, RR pointer=0.
REQ-028 SHALL discard all buffered and in-flight words on reset mid-operation; first post-reset edge behaves as from cold.

Configuration
REQ-029 SHALL, with MCDT_NCH_PRIO_EN defined, replace round-robin by fixed priority (lowest index wins, no pointer state); without it, REQ-025/026 apply.

Verification
REQ-030 SHALL cover: rst_i=1 mid-run -> immediately ch_margin_o=32 all, ch_ready_o=3'b111, mcdt_val_o=0.
REQ-031 SHALL cover: single write ch1 data 0x00C1_0000 at edge k, mcdt_ready_i=1 -> after k+1 val=1, data=0x00C1_0000, id=1; ch1 margin 31 then 32.
REQ-032 SHALL cover: mcdt_ready_i=0, ch0 valid every cycle -> 33 words accepted (1 output reg + 32 FIFO), then ch_ready_o[0]=0, margin 0, output holds 0x00C0_0000.
REQ-033 SHALL cover: 3 channels preloaded 4 words each, mcdt_ready_i=1 -> ids 0,1,2,0,1,2,... 12 words, per-channel order kept; with MCDT_NCH_PRIO_EN -> ids 0x4,1x4,2x4.
REQ-034 SHALL cover: ch2 at margin 16, one push and one pop same edge -> margin stays 16.
REQ-035 SHALL cover: NCH=4, DEPTH=8 instance, mcdt_ready_i toggling 50% random, 500 words/channel -> scoreboard match, all margins return to 8.

Source files
------------

// File: rtl/mcdt_nch.sv
// Multi-channel data merger: NCH per-channel FIFOs arbitrated into one output register.
// Define MCDT_NCH_PRIO_EN for fixed lowest-index priority instead of round-robin.
module mcdt_nch #(
    parameter int NCH   = 3,
    parameter int DW    = 32,
    parameter int DEPTH = 32,
    localparam int MW   = $clog2(DEPTH) + 1,
    localparam int IW   = $clog2(NCH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NCH*DW-1:0] ch_data_i,
    input  logic [NCH-1:0]    ch_valid_i,
    output logic [NCH-1:0]    ch_ready_o,
    output logic [NCH*MW-1:0] ch_margin_o,
    output logic [DW-1:0]     mcdt_data_o,
    output logic              mcdt_val_o,
    output logic [IW-1:0]     mcdt_id_o,
    input  logic              mcdt_ready_i
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0]  mem [NCH][DEPTH];
    logic [AW-1:0]  wr_ptr [NCH];
    logic [AW-1:0]  rd_ptr [NCH];
    logic [MW-1:0]  cnt [NCH];
    logic [NCH-1:0] req;
    logic [NCH-1:0] push;
    logic [NCH-1:0] pop;
    logic [IW-1:0]  grant;
    logic [IW-1:0]  rr_ptr;
    logic           found;
    logic           load;

    for (genvar n = 0; n < NCH; n++) begin : g_ch
        assign ch_ready_o[n]            = (cnt[n] != MW'(DEPTH));
        assign ch_margin_o[n*MW +: MW]  = MW'(DEPTH) - cnt[n];
        assign req[n]                   = (cnt[n] != '0);
        assign push[n]                  = ch_valid_i[n] & (cnt[n] != MW'(DEPTH));
    end

    // The output register refills whenever it is empty or its word is being taken.
    assign load = ~mcdt_val_o | mcdt_ready_i;

    always_comb begin
        found = 1'b0;
        grant = '0;
        for (int i = 0; i < NCH; i++) begin
            if (!found && req[(int'(rr_ptr) + i) % NCH]) begin
                found = 1'b1;
                grant = IW'((int'(rr_ptr) + i) % NCH);
            end
        end
    end

    always_comb begin
        pop = '0;
        if (load && found) begin
            pop[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int n = 0; n < NCH; n++) begin
            if (push[n]) begin
                mem[n][wr_ptr[n]] <= ch_data_i[n*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int n = 0; n < NCH; n++) begin
                wr_ptr[n] <= '0;
                rd_ptr[n] <= '0;
                cnt[n]    <= '0;
            end
        end else begin
            for (int n = 0; n < NCH; n++) begin
                if (push[n]) begin
                    wr_ptr[n] <= wr_ptr[n] + 1'b1;
                end
                if (pop[n]) begin
                    rd_ptr[n] <= rd_ptr[n] + 1'b1;
                end
                case ({push[n], pop[n]})
                    2'b10:   cnt[n] <= cnt[n] + 1'b1;
                    2'b01:   cnt[n] <= cnt[n] - 1'b1;
                    default: cnt[n] <= cnt[n];
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mcdt_val_o  <= 1'b0;
            mcdt_data_o <= '0;
            mcdt_id_o   <= '0;
        end else if (load) begin
            if (found) begin
                mcdt_val_o  <= 1'b1;
                mcdt_data_o <= mem[grant][rd_ptr[grant]];
                mcdt_id_o   <= grant;
            end else begin
                mcdt_val_o  <= 1'b0;
            end
        end
    end

`ifdef MCDT_NCH_PRIO_EN
    assign rr_ptr = '0;
`else
    // Search restarts just past the last granted channel; moves only when a word is loaded.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr <= '0;
        end else if (load && found) begin
            rr_ptr <= (grant == IW'(NCH - 1)) ? '0 : grant + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mcdt_nch.sv
// Bench for mcdt_nch: a default instance (NCH=3, DEPTH=32) and a small one (NCH=4, DEPTH=8),
// checked against a queue-based reference model of the merger.
module tb_mcdt_nch;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   sel_b = 1'b0;

    always #5 clk = ~clk;

    logic [31:0] drv_d [4];
    logic [3:0]  drv_v = '0;
    logic        drv_rdy = 1'b0;

    logic [95:0]  data_a;
    logic [2:0]   valid_a, ready_a;
    logic [17:0]  margin_a;
    logic [31:0]  out_a;
    logic         val_a;
    logic [1:0]   id_a;

    logic [127:0] data_b;
    logic [3:0]   valid_b, ready_b;
    logic [15:0]  margin_b;
    logic [31:0]  out_b;
    logic         val_b;
    logic [1:0]   id_b;

    assign data_a  = {drv_d[2], drv_d[1], drv_d[0]};
    assign valid_a = sel_b ? 3'b000 : drv_v[2:0];
    assign data_b  = {drv_d[3], drv_d[2], drv_d[1], drv_d[0]};
    assign valid_b = sel_b ? drv_v : 4'b0000;

    mcdt_nch dut_a (
        .clk_i(clk), .rst_i(rst), .ch_data_i(data_a), .ch_valid_i(valid_a),
        .ch_ready_o(ready_a), .ch_margin_o(margin_a), .mcdt_data_o(out_a),
        .mcdt_val_o(val_a), .mcdt_id_o(id_a), .mcdt_ready_i(drv_rdy)
    );

    mcdt_nch #(.NCH(4), .DW(32), .DEPTH(8)) dut_b (
        .clk_i(clk), .rst_i(rst), .ch_data_i(data_b), .ch_valid_i(valid_b),
        .ch_ready_o(ready_b), .ch_margin_o(margin_b), .mcdt_data_o(out_b),
        .mcdt_val_o(val_b), .mcdt_id_o(id_b), .mcdt_ready_i(drv_rdy)
    );

    logic        obs_val;
    logic [31:0] obs_data;
    int          obs_id;
    int          obs_margin [4];
    logic [3:0]  obs_ready;

    always_comb begin
        obs_val  = sel_b ? val_b : val_a;
        obs_data = sel_b ? out_b : out_a;
        obs_id   = sel_b ? int'(id_b) : int'(id_a);
        obs_ready = sel_b ? ready_b : {1'b0, ready_a};
        obs_margin[0] = sel_b ? int'(margin_b[3:0])   : int'(margin_a[5:0]);
        obs_margin[1] = sel_b ? int'(margin_b[7:4])   : int'(margin_a[11:6]);
        obs_margin[2] = sel_b ? int'(margin_b[11:8])  : int'(margin_a[17:12]);
        obs_margin[3] = sel_b ? int'(margin_b[15:12]) : 0;
    end

    int checks = 0;
    int failures = 0;

    // Reference model: FIFO contents as queues, one output slot, next-search pointer.
    logic [31:0] mq [4][$];
    logic [31:0] exp_q [$];
    bit          m_acc [4];
    bit          m_val;
    logic [31:0] m_data;
    int          m_id, m_ptr, m_nch, m_depth;

    task automatic model_reset(input int nch, input int depth);
        for (int n = 0; n < 4; n++) begin
            mq[n].delete();
            m_acc[n] = 1'b0;
        end
        m_val = 1'b0; m_data = '0; m_id = 0; m_ptr = 0;
        m_nch = nch; m_depth = depth;
    endtask

    task automatic step();
        bit load, found;
        int g, c;
        for (int n = 0; n < 4; n++)
            m_acc[n] = (n < m_nch) && drv_v[n] && (mq[n].size() < m_depth);
        load = !m_val || drv_rdy;
        found = 1'b0; g = 0; c = 0;
        if (load) begin
            for (int k = 0; k < m_nch; k++) begin
`ifdef MCDT_NCH_PRIO_EN
                c = k;
`else
                c = (m_ptr + k) % m_nch;
`endif
                if (!found && mq[c].size() > 0) begin
                    found = 1'b1;
                    g = c;
                end
            end
            if (found) begin
                m_data = mq[g].pop_front();
                m_id = g; m_val = 1'b1; m_ptr = (g + 1) % m_nch;
            end else begin
                m_val = 1'b0;
            end
        end
        for (int n = 0; n < 4; n++)
            if (m_acc[n]) mq[n].push_back(drv_d[n]);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int nch, input int depth);
        drv_v = '0; drv_rdy = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        model_reset(nch, depth);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        for (int n = 0; n < 3; n++) begin
            checks++;
            if (obs_margin[n] !== 32) begin
                failures++; $display("FAIL reset_margin ch%0d: got %0d expected 32", n, obs_margin[n]);
            end
        end
        checks++;
        if (obs_ready[2:0] !== 3'b111) begin
            failures++; $display("FAIL reset_ready: got %b expected 111", obs_ready[2:0]);
        end
        checks++;
        if (obs_val !== 1'b0 || obs_data !== 32'h0 || obs_id !== 0) begin
            failures++; $display("FAIL reset_out: got val=%b data=%h id=%0d expected 0/0/0", obs_val, obs_data, obs_id);
        end
        @(negedge clk);
        model_reset(3, 32);
        rst = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset(3, 32);
        for (int i = 0; i < 6; i++) begin
            drv_v = 4'b0011;
            drv_d[0] = $urandom; drv_d[1] = $urandom;
            step();
        end
        drv_v = '0;
        rst = 1'b1;
        #2;
        checks++;
        if (obs_margin[0] !== 32 || obs_margin[1] !== 32 || obs_margin[2] !== 32) begin
            failures++; $display("FAIL midreset_margin: got %0d %0d %0d expected 32 32 32", obs_margin[0], obs_margin[1], obs_margin[2]);
        end
        checks++;
        if (obs_ready[2:0] !== 3'b111 || obs_val !== 1'b0) begin
            failures++; $display("FAIL midreset_ready_val: got ready=%b val=%b expected 111 0", obs_ready[2:0], obs_val);
        end
        @(negedge clk);
        model_reset(3, 32);
        rst = 1'b0;
        drv_rdy = 1'b1;
        step();
        checks++;
        if (obs_val !== 1'b0 || obs_margin[0] !== 32) begin
            failures++; $display("FAIL midreset_cold: got val=%b margin0=%0d expected 0 32", obs_val, obs_margin[0]);
        end
    endtask

    task automatic test_single_write();
        do_reset(3, 32);
        drv_rdy = 1'b1;
        drv_v = 4'b0010; drv_d[1] = 32'h00C1_0000;
        step();
        drv_v = '0;
        checks++;
        if (obs_margin[1] !== 31 || obs_val !== 1'b0) begin
            failures++; $display("FAIL single_k: got margin1=%0d val=%b expected 31 0", obs_margin[1], obs_val);
        end
        step();
        checks++;
        if (obs_val !== 1'b1 || obs_data !== 32'h00C1_0000 || obs_id !== 1) begin
            failures++; $display("FAIL single_out: got val=%b data=%h id=%0d expected 1 00c10000 1", obs_val, obs_data, obs_id);
        end
        checks++;
        if (obs_margin[1] !== 32) begin
            failures++; $display("FAIL single_margin: got %0d expected 32", obs_margin[1]);
        end
    endtask

    task automatic test_fill();
        int cnt;
        do_reset(3, 32);
        for (int i = 0; i < 40; i++) begin
            drv_v = 4'b0001; drv_d[0] = 32'h00C0_0000 + 32'(i);
            step();
        end
        drv_v = '0;
        checks++;
        if (obs_ready[0] !== 1'b0 || obs_margin[0] !== 0) begin
            failures++; $display("FAIL fill_full: got ready0=%b margin0=%0d expected 0 0", obs_ready[0], obs_margin[0]);
        end
        checks++;
        if (obs_val !== 1'b1 || obs_data !== 32'h00C0_0000 || obs_id !== 0) begin
            failures++; $display("FAIL fill_hold: got val=%b data=%h id=%0d expected 1 00c00000 0", obs_val, obs_data, obs_id);
        end
        for (int i = 0; i < 33; i++) exp_q.push_back(32'h00C0_0000 + 32'(i));
        drv_rdy = 1'b1;
        cnt = 0;
        for (int c = 0; c < 60; c++) begin
            if (obs_val && drv_rdy) begin
                checks++;
                if (exp_q.size() == 0 || obs_data !== exp_q[0]) begin
                    failures++; $display("FAIL fill_drain word %0d: got %h expected %h", cnt, obs_data, exp_q.size() ? exp_q[0] : 32'hx);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                cnt++;
            end
            step();
        end
        checks++;
        if (cnt !== 33) begin
            failures++; $display("FAIL fill_count: got %0d expected 33", cnt);
        end
        exp_q.delete();
    endtask

    task automatic test_round_robin();
        int cnt, eid, eseq;
        do_reset(3, 32);
        for (int s = 0; s < 4; s++) begin
            drv_v = 4'b0111;
            for (int n = 0; n < 3; n++) drv_d[n] = 32'h00C0_0000 | (32'(n) << 16) | 32'(s);
            step();
        end
        drv_v = '0;
        drv_rdy = 1'b1;
        cnt = 0;
        for (int c = 0; c < 30; c++) begin
            if (obs_val && drv_rdy) begin
`ifdef MCDT_NCH_PRIO_EN
                eid = cnt / 4; eseq = cnt % 4;
`else
                eid = cnt % 3; eseq = cnt / 3;
`endif
                checks++;
                if (obs_id !== eid || obs_data !== (32'h00C0_0000 | (32'(eid) << 16) | 32'(eseq))) begin
                    failures++; $display("FAIL rr word %0d: got id=%0d data=%h expected id=%0d seq=%0d", cnt, obs_id, obs_data, eid, eseq);
                end
                cnt++;
            end
            step();
        end
        checks++;
        if (cnt !== 12) begin
            failures++; $display("FAIL rr_count: got %0d expected 12", cnt);
        end
    endtask

    task automatic test_same_edge();
        do_reset(3, 32);
        for (int i = 0; i < 17; i++) begin
            drv_v = 4'b0100; drv_d[2] = 32'h00C2_0000 + 32'(i);
            step();
        end
        checks++;
        if (obs_margin[2] !== 16) begin
            failures++; $display("FAIL same_pre: got margin2=%0d expected 16", obs_margin[2]);
        end
        drv_d[2] = 32'h00C2_0011; drv_rdy = 1'b1;
        step();
        drv_v = '0; drv_rdy = 1'b0;
        checks++;
        if (obs_margin[2] !== 16) begin
            failures++; $display("FAIL same_edge: got margin2=%0d expected 16", obs_margin[2]);
        end
        checks++;
        if (obs_val !== 1'b1 || obs_data !== 32'h00C2_0001 || obs_id !== 2) begin
            failures++; $display("FAIL same_out: got val=%b data=%h id=%0d expected 1 00c20001 2", obs_val, obs_data, obs_id);
        end
    endtask

    task automatic test_random();
        int sent [4];
        int rcv [4];
        int cyc;
        bit done;
        sel_b = 1'b1;
        do_reset(4, 8);
        for (int n = 0; n < 4; n++) begin sent[n] = 0; rcv[n] = 0; end
        cyc = 0; done = 1'b0;
        while (!done && cyc < 20000) begin
            for (int n = 0; n < 4; n++) begin
                drv_v[n] = (sent[n] < 500) && ($urandom_range(0, 1) == 1);
                drv_d[n] = (32'(n) << 16) | 32'(sent[n]);
            end
            drv_rdy = ($urandom_range(0, 1) == 1);
            if (obs_val && drv_rdy) begin
                checks++;
                if (obs_id < 0 || obs_id > 3 || obs_data !== ((32'(obs_id) << 16) | 32'(rcv[obs_id & 3]))) begin
                    failures++; $display("FAIL rand_order: got id=%0d data=%h expected seq %0d", obs_id, obs_data, rcv[obs_id & 3]);
                end
                rcv[obs_id & 3]++;
            end
            step();
            for (int n = 0; n < 4; n++) if (m_acc[n]) sent[n]++;
            checks++;
            if (obs_val !== m_val || (m_val && (obs_data !== m_data || obs_id !== m_id))) begin
                failures++; $display("FAIL rand_out cyc %0d: got val=%b data=%h id=%0d expected val=%b data=%h id=%0d", cyc, obs_val, obs_data, obs_id, m_val, m_data, m_id);
            end
            for (int n = 0; n < 4; n++) begin
                checks++;
                if (obs_margin[n] !== 8 - mq[n].size() || obs_ready[n] !== (mq[n].size() < 8)) begin
                    failures++; $display("FAIL rand_margin ch%0d cyc %0d: got %0d expected %0d", n, cyc, obs_margin[n], 8 - mq[n].size());
                end
            end
            done = !m_val;
            for (int n = 0; n < 4; n++) if (sent[n] < 500 || mq[n].size() != 0) done = 1'b0;
            cyc++;
        end
        drv_v = '0;
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (rcv[n] !== 500 || obs_margin[n] !== 8) begin
                failures++; $display("FAIL rand_final ch%0d: got rcv=%0d margin=%0d expected 500 8", n, rcv[n], obs_margin[n]);
            end
        end
        sel_b = 1'b0;
    endtask

    initial begin
        for (int n = 0; n < 4; n++) drv_d[n] = '0;
        test_reset();
        test_reset_mid();
        test_single_write();
        test_fill();
        test_round_robin();
        test_same_edge();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
